// File: rtl/calc_display_pkg.sv
// calc_display_pkg: shared states, glyph codes and segment patterns for the display scanner
package calc_display_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_SHOW} state_t;
  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_MINUS = 5'h11;
  localparam logic [4:0] GLYPH_H     = 5'h12;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_H     = 7'b0001011;
  // active-low {g,f,e,d,c,b,a}, indexed 0..F
  localparam logic [6:0] SEG_DIGIT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/seven_seg_encoder.sv
// seven_seg_encoder: maps a 5-bit glyph code to active-low segment pattern
module seven_seg_encoder
  import calc_display_pkg::*;
(
  input  logic [4:0] glyph,
  output logic [6:0] seg
);
  always_comb
    seg = glyph[4] ? (glyph == GLYPH_MINUS ? SEG_MINUS : glyph == GLYPH_H ? SEG_H : SEG_BLANK)
                   : SEG_DIGIT[glyph[3:0]];
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: accepts ALU results, drives an external converter and scans 4 digits
module display_scan_controller
  import calc_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_valid,
  input  logic [5:0] result_data,
  input  logic       display_mode,
  output logic       result_ready,
  output logic [5:0] conv_data,
  output logic       conv_mode,
  input  logic [3:0] conv_digit0,
  input  logic [3:0] conv_digit1,
  input  logic       conv_neg,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0] slot_q;
  logic [5:0] data_q;
  logic mode_q;
  logic [3:0] dig0_q, dig1_q;
  logic neg_q, hex_q, shown_q;
  logic accept, remode, wrap;
  logic [4:0] glyph;
  logic [6:0] glyph_seg;
  assign result_ready = ~rst & (state_q != ST_CONVERT);
  assign accept = result_valid & result_ready;
  assign remode = (state_q == ST_SHOW) & ~accept & (display_mode != mode_q);
  assign wrap = cnt_q == CW'(REFRESH_DIV - 1);
  assign conv_data = data_q;
  assign conv_mode = mode_q;
  assign dp = 1'b1;
  always_comb
    state_d = (accept | remode) ? ST_CONVERT : state_q == ST_CONVERT ? ST_SHOW : state_q;
  // nothing captured yet (first convert after reset) shows all blanks
  always_comb begin
    glyph = GLYPH_BLANK;
    if (state_q != ST_IDLE && shown_q)
      glyph = slot_q == 2'd0 ? {1'b0, dig0_q}
            : slot_q == 2'd1 ? ((BLANK_LEADING && !hex_q && dig1_q == 4'd0) ? GLYPH_BLANK : {1'b0, dig1_q})
            : slot_q == 2'd2 ? (neg_q ? GLYPH_MINUS : GLYPH_BLANK)
            : (hex_q ? GLYPH_H : GLYPH_BLANK);
  end
  seven_seg_encoder u_enc (.glyph(glyph), .seg(glyph_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      slot_q <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      dig0_q <= '0;
      dig1_q <= '0;
      neg_q <= 1'b0;
      hex_q <= 1'b0;
      shown_q <= 1'b0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) slot_q <= slot_q + 2'd1;
      if (accept) begin
        data_q <= result_data;
        mode_q <= display_mode;
      end else if (remode) mode_q <= display_mode;
      if (state_q == ST_CONVERT) begin
        dig0_q <= conv_digit0;
        dig1_q <= conv_digit1;
        neg_q <= conv_neg;
        hex_q <= mode_q;
        shown_q <= 1'b1;
      end
      an <= state_q == ST_IDLE ? 4'b1111 : ~(4'b0001 << slot_q);
      seg <= glyph_seg;
    end
  end
endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, is the number of clk cycles each digit slot is held; legal range is 2..2^20.
REQ-002 Parameter BLANK_LEADING, default 1; when set to 1, a leading decimal zero in slot 1 is blanked.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 result_valid  input  1  ALU result offer.
REQ-006 result_data  input  6  signed ALU result, range -32..31.
REQ-007 display_mode  input  1  0 selects decimal, 1 selects hex.
REQ-008 result_ready  output  1  controller can accept a result.
REQ-009 conv_data  output  6  operand driven to the digit converter.
REQ-010 conv_mode  output  1  mode driven to the digit converter.
REQ-011 conv_digit0, conv_digit1  input  4 each  converter ones/low and tens/high digits.
REQ-012 conv_neg  input  1  converter negative flag.
REQ-013 an  output  4  active-low digit anodes; an[k] enables slot k.
REQ-014 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-015 dp  output  1  active-low decimal point; always 1 (off).

Function
REQ-016 The controller SHALL implement the states IDLE, CONVERT and SHOW.
REQ-017 Results are accepted on any cycle with result_valid & result_ready; result_ready SHALL be 1 in IDLE and SHOW and 0 in CONVERT.
- On accept: result_data is latched into data_q, display_mode into mode_q, and the next state is CONVERT.
REQ-018 conv_data and conv_mode SHALL be driven from data_q and mode_q at all times.
REQ-019 CONVERT SHALL last exactly one cycle. At its end, conv_digit0, conv_digit1 and conv_neg are captured into the display registers, and the next state is SHOW.
REQ-020 In SHOW, if display_mode != mode_q and no accept occurs, mode_q SHALL take the new value and the state SHALL go to CONVERT (re-conversion of the stored data).
REQ-021 Simultaneous accept and mode change SHALL be treated as an accept only, using the display_mode value sampled in that cycle.
REQ-022 A free-running refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On each wrap, the 2-bit slot index advances by one, with 3 wrapping to 0.
REQ-023 Slot glyphs SHALL be:
- slot0 = digit0;
- slot1 = digit1, or blank if BLANK_LEADING=1, mode is decimal and digit1=0;
- slot2 = '-' if neg, otherwise blank;
- slot3 = 'h' in hex mode, otherwise blank.
REQ-024 an and seg SHALL be registered and reflect a slot index change one cycle after it occurs.
- In IDLE, an = 4'b1111.
- Otherwise an = ~(1 << slot).
REQ-025 During CONVERT the previously captured digits SHALL remain displayed; on the first CONVERT after IDLE, all slots show blank.
REQ-026 Hex digits A..F SHALL display as A, b, C, d, E, F. Blank SHALL be seg = 7'b1111111, '-' SHALL be 7'b0111111, and 'h' SHALL be 7'b0001011.

Reset
REQ-027 While rst=1, state SHALL go to IDLE, and the refresh counter, slot index, data_q, mode_q and the display registers SHALL clear to 0.
- Outputs during rst: an=4'b1111, seg=7'b1111111, dp=1, result_ready=0.
REQ-028 result_ready SHALL assert on the first cycle after rst deasserts.
REQ-029 Reset asserted during CONVERT or SHOW SHALL abandon the operation; no digit capture occurs in that cycle.

Structure
REQ-030 Package calc_display_pkg SHALL hold:
- the state enum;
- the 5-bit glyph codes (0x0..0xF as digits, GLYPH_BLANK, GLYPH_MINUS, GLYPH_H);
- the seg pattern constants.
REQ-031 A combinational sub-module seven_seg_encoder SHALL map a glyph code to seg; the controller instantiates it once, and its output is registered.
REQ-032 The digit converter is instantiated outside this block and is connected through the conv_* ports.

Verification (bench uses REFRESH_DIV=4)
REQ-033 Decimal mode, accept -27 → result_ready is 0 for exactly one cycle; then the slots show 7, 2, '-', blank.
REQ-034 Hex mode, accept 31 → slots show F, 1, blank, 'h'; accept -32 in decimal → slots show 2, 3, '-', blank.
REQ-035 Decimal mode, accept 5 → slot1 is blank; with BLANK_LEADING=0, slot1 shows 0.
REQ-036 Accept 20 in decimal, then toggle display_mode in SHOW → one CONVERT cycle occurs and the slots become 4, 1, blank, 'h'.
REQ-037 Accept 9 in mode 0 in the same cycle that display_mode rises → mode_q=1 and exactly one CONVERT occurs; then assert rst mid-CONVERT → an=4'b1111 next cycle and result_ready=1 the cycle after rst drops.
REQ-038 Anode rotation → with REFRESH_DIV=4, an cycles 1110, 1101, 1011, 0111, and each value holds 4 cycles.
